// File: rtl/vga_game_scheduler.sv
// Once-per-frame game controller: debounced switches move the plane, the hit
// strobe drives a PLAY/CRASH/RESPAWN state machine, and the clouds scroll.
module vga_game_scheduler #(
  parameter int H_DISPLAY       = 640,
  parameter int V_DISPLAY       = 480,
  parameter int TRI_HALF_BASE   = 75,
  parameter int TRI_HEIGHT      = 100,
  parameter int MOVE_DIV        = 4,
  parameter int CLOUD_DIV       = 2,
  parameter int CRASH_FRAMES    = 120,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [3:0] sw,
  input  logic       hit_pixel,
  output logic [9:0] center_x,
  output logic [9:0] center_y,
  output logic [9:0] cloud_offset,
  output logic [1:0] game_state,
  output logic       crash_flash,
  output logic [7:0] crash_count
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int unsigned MW  = $clog2(MOVE_DIV + 1);
  localparam int unsigned CW  = $clog2(CLOUD_DIV + 1);

  localparam logic [9:0] X_MIN      = 10'(TRI_HALF_BASE + 1);
  localparam logic [9:0] X_MAX      = 10'(H_DISPLAY - TRI_HALF_BASE - 1);
  localparam logic [9:0] Y_MIN      = 10'(TRI_HEIGHT / 2 + 1);
  localparam logic [9:0] Y_MAX      = 10'(V_DISPLAY - TRI_HEIGHT / 2 - 1);
  localparam logic [9:0] X_HOME     = 10'(H_DISPLAY / 2);
  localparam logic [9:0] Y_HOME     = 10'(V_DISPLAY / 2);
  localparam logic [9:0] CLOUD_LAST = 10'(H_DISPLAY - 1);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_FRAMES - 1);
  localparam logic [MW-1:0]  MOVE_LAST  = MW'(MOVE_DIV - 1);
  localparam logic [CW-1:0]  CDIV_LAST  = CW'(CLOUD_DIV - 1);
  localparam logic [7:0]     TIMER_LOAD = 8'(CRASH_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_CRASH   = 2'd1,
    ST_RESPAWN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          sw_meta_q, sw_meta_d;
  logic [3:0]          sw_sync_q, sw_sync_d;
  logic [3:0]          sw_db_q, sw_db_d;
  logic [3:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic                hit_q, hit_d;
  logic [MW-1:0]       move_ctr_q, move_ctr_d;
  logic [CW-1:0]       cdiv_q, cdiv_d;
  logic [7:0]          timer_q, timer_d;
  logic [7:0]          flash_ctr_q, flash_ctr_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic [9:0]          cloud_q, cloud_d;
  logic                flash_q, flash_d;
  logic [7:0]          count_q, count_d;
  logic                hit_eval;

  always_comb begin
    state_d     = state_q;
    sw_meta_d   = sw;
    sw_sync_d   = sw_meta_q;
    sw_db_d     = sw_db_q;
    db_cnt_d    = db_cnt_q;
    move_ctr_d  = move_ctr_q;
    cdiv_d      = cdiv_q;
    timer_d     = timer_q;
    flash_ctr_d = flash_ctr_q;
    x_d         = x_q;
    y_d         = y_q;
    cloud_d     = cloud_q;
    flash_d     = flash_q;
    count_d     = count_q;

    // A hit in the tick cycle itself still belongs to the frame that is ending.
    hit_eval = hit_q | hit_pixel;
    hit_d    = frame_tick ? 1'b0 : hit_eval;

    if (frame_tick) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sw_sync_q[i] == sw_db_q[i]) begin
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_d[i] = '0;
          sw_db_d[i]  = sw_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end

      if (state_q != ST_CRASH) begin
        if (cdiv_q == CDIV_LAST) begin
          cdiv_d  = '0;
          cloud_d = (cloud_q == CLOUD_LAST) ? '0 : cloud_q + 10'd1;
        end else begin
          cdiv_d = cdiv_q + 1'b1;
        end
      end

      case (state_q)
        ST_PLAY: begin
          if (hit_eval) begin
            state_d     = ST_CRASH;
            timer_d     = TIMER_LOAD;
            flash_ctr_d = '0;
            flash_d     = 1'b0;
            if (count_q != '1) count_d = count_q + 8'd1;
          end else if (move_ctr_q == MOVE_LAST) begin
            move_ctr_d = '0;
            case (sw_db_q[1:0])
              2'b01:   x_d = (x_q <= X_MIN) ? X_MIN : x_q - 10'd1;
              2'b10:   x_d = (x_q >= X_MAX) ? X_MAX : x_q + 10'd1;
              default: x_d = x_q;
            endcase
            case (sw_db_q[3:2])
              2'b01:   y_d = (y_q <= Y_MIN) ? Y_MIN : y_q - 10'd1;
              2'b10:   y_d = (y_q >= Y_MAX) ? Y_MAX : y_q + 10'd1;
              default: y_d = y_q;
            endcase
          end else begin
            move_ctr_d = move_ctr_q + 1'b1;
          end
        end
        ST_CRASH: begin
          if (timer_q == '0) begin
            state_d    = ST_RESPAWN;
            x_d        = X_HOME;
            y_d        = Y_HOME;
            flash_d    = 1'b0;
            move_ctr_d = '0;
          end else begin
            timer_d     = timer_q - 8'd1;
            flash_ctr_d = flash_ctr_q + 8'd1;
            flash_d     = flash_ctr_d[3];
          end
        end
        ST_RESPAWN: state_d = ST_PLAY;
        default:    state_d = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      state_q     <= ST_PLAY;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_db_q     <= '0;
      db_cnt_q    <= '0;
      hit_q       <= 1'b0;
      move_ctr_q  <= '0;
      cdiv_q      <= '0;
      timer_q     <= '0;
      flash_ctr_q <= '0;
      x_q         <= X_HOME;
      y_q         <= Y_HOME;
      cloud_q     <= '0;
      flash_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      sw_db_q     <= sw_db_d;
      db_cnt_q    <= db_cnt_d;
      hit_q       <= hit_d;
      move_ctr_q  <= move_ctr_d;
      cdiv_q      <= cdiv_d;
      timer_q     <= timer_d;
      flash_ctr_q <= flash_ctr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cloud_q     <= cloud_d;
      flash_q     <= flash_d;
      count_q     <= count_d;
    end
  end

  assign center_x     = x_q;
  assign center_y     = y_q;
  assign cloud_offset = cloud_q;
  assign game_state   = state_q;
  assign crash_flash  = flash_q;
  assign crash_count  = count_q;

endmodule

// File: tb/tb_vga_game_scheduler.sv
// Directed scenarios for vga_game_scheduler with hand-computed expectations.
module tb_vga_game_scheduler;

  logic       clk_25MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic       hit_pixel = 1'b0;
  logic [9:0] center_x, center_y, cloud_offset;
  logic [1:0] game_state;
  logic       crash_flash;
  logic [7:0] crash_count;

  int total = 0;
  int bad = 0;

  vga_game_scheduler #(.H_DISPLAY(640), .V_DISPLAY(480)) dut (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .sw          (sw),
    .hit_pixel   (hit_pixel),
    .center_x    (center_x),
    .center_y    (center_y),
    .cloud_offset(cloud_offset),
    .game_state  (game_state),
    .crash_flash (crash_flash),
    .crash_count (crash_count)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic do_reset(input logic [3:0] sw_val);
    @(negedge clk_25MHz);
    sw = sw_val; rst_n = 1'b0; frame_tick = 1'b0; hit_pixel = 1'b0;
    repeat (2) @(negedge clk_25MHz);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_25MHz);
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk_25MHz); frame_tick = 1'b1;
      @(negedge clk_25MHz); frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_hit();
    @(negedge clk_25MHz); hit_pixel = 1'b1;
    @(negedge clk_25MHz); hit_pixel = 1'b0;
    repeat (2) @(negedge clk_25MHz);
  endtask

  task automatic test_reset();
    do_reset(4'b0000);
    total++; if (center_x !== 10'd320) begin bad++; $display("FAIL reset_x got %0d exp 320", center_x); end
    total++; if (center_y !== 10'd240) begin bad++; $display("FAIL reset_y got %0d exp 240", center_y); end
    total++; if (cloud_offset !== 10'd0) begin bad++; $display("FAIL reset_cloud got %0d exp 0", cloud_offset); end
    total++; if (game_state !== 2'd0) begin bad++; $display("FAIL reset_state got %0d exp 0", game_state); end
    total++; if (crash_flash !== 1'b0) begin bad++; $display("FAIL reset_flash got %0b exp 0", crash_flash); end
    total++; if (crash_count !== 8'd0) begin bad++; $display("FAIL reset_count got %0d exp 0", crash_count); end
  endtask

  task automatic test_move_right();
    do_reset(4'b0010);
    tick(3);
    total++; if (center_x !== 10'd320) begin bad++; $display("FAIL right_t3 got %0d exp 320", center_x); end
    tick(1);
    total++; if (center_x !== 10'd321) begin bad++; $display("FAIL right_t4 got %0d exp 321", center_x); end
    tick(36);
    total++; if (center_x !== 10'd330) begin bad++; $display("FAIL right_t40 got %0d exp 330", center_x); end
    total++; if (center_y !== 10'd240) begin bad++; $display("FAIL right_y got %0d exp 240", center_y); end
    total++; if (game_state !== 2'd0) begin bad++; $display("FAIL right_state got %0d exp 0", game_state); end
    total++; if (cloud_offset !== 10'd20) begin bad++; $display("FAIL right_cloud got %0d exp 20", cloud_offset); end
  endtask

  task automatic test_clamp();
    do_reset(4'b0001);
    tick(2000);
    total++; if (center_x !== 10'd76) begin bad++; $display("FAIL clamp_left got %0d exp 76", center_x); end
    sw = 4'b0011;
    tick(40);
    total++; if (center_x !== 10'd76) begin bad++; $display("FAIL clamp_both got %0d exp 76", center_x); end
    sw = 4'b0010;
    tick(2000);
    total++; if (center_x !== 10'd564) begin bad++; $display("FAIL clamp_right got %0d exp 564", center_x); end
    sw = 4'b0100;
    tick(1000);
    total++; if (center_y !== 10'd51) begin bad++; $display("FAIL clamp_up got %0d exp 51", center_y); end
    sw = 4'b1000;
    tick(2000);
    total++; if (center_y !== 10'd429) begin bad++; $display("FAIL clamp_down got %0d exp 429", center_y); end
    total++; if (center_x !== 10'd564) begin bad++; $display("FAIL clamp_x_hold got %0d exp 564", center_x); end
  endtask

  task automatic test_crash_cycle();
    do_reset(4'b0000);
    tick(5);
    pulse_hit();
    total++; if (game_state !== 2'd0) begin bad++; $display("FAIL crash_wait_tick got %0d exp 0", game_state); end
    tick(1);
    total++; if (game_state !== 2'd1) begin bad++; $display("FAIL crash_enter got %0d exp 1", game_state); end
    total++; if (crash_count !== 8'd1) begin bad++; $display("FAIL crash_count1 got %0d exp 1", crash_count); end
    total++; if (cloud_offset !== 10'd3) begin bad++; $display("FAIL crash_cloud_entry got %0d exp 3", cloud_offset); end
    tick(7);
    total++; if (crash_flash !== 1'b0) begin bad++; $display("FAIL flash_t7 got %0b exp 0", crash_flash); end
    tick(1);
    total++; if (crash_flash !== 1'b1) begin bad++; $display("FAIL flash_t8 got %0b exp 1", crash_flash); end
    pulse_hit();
    tick(8);
    total++; if (crash_flash !== 1'b0) begin bad++; $display("FAIL flash_t16 got %0b exp 0", crash_flash); end
    total++; if (crash_count !== 8'd1) begin bad++; $display("FAIL crash_hit_ignored got %0d exp 1", crash_count); end
    total++; if (cloud_offset !== 10'd3) begin bad++; $display("FAIL crash_cloud_frozen got %0d exp 3", cloud_offset); end
    tick(103);
    total++; if (game_state !== 2'd1) begin bad++; $display("FAIL crash_t119 got %0d exp 1", game_state); end
    tick(1);
    total++; if (game_state !== 2'd2) begin bad++; $display("FAIL respawn_enter got %0d exp 2", game_state); end
    total++; if (center_x !== 10'd320) begin bad++; $display("FAIL respawn_x got %0d exp 320", center_x); end
    total++; if (center_y !== 10'd240) begin bad++; $display("FAIL respawn_y got %0d exp 240", center_y); end
    total++; if (crash_flash !== 1'b0) begin bad++; $display("FAIL respawn_flash got %0b exp 0", crash_flash); end
    pulse_hit();
    tick(1);
    total++; if (game_state !== 2'd0) begin bad++; $display("FAIL respawn_to_play got %0d exp 0", game_state); end
    total++; if (crash_count !== 8'd1) begin bad++; $display("FAIL respawn_hit_ignored got %0d exp 1", crash_count); end
    tick(1);
    total++; if (game_state !== 2'd0) begin bad++; $display("FAIL play_after_respawn got %0d exp 0", game_state); end
    total++; if (cloud_offset !== 10'd4) begin bad++; $display("FAIL cloud_resume got %0d exp 4", cloud_offset); end
    // Hit in the very cycle of the tick must still crash at that tick.
    @(negedge clk_25MHz); frame_tick = 1'b1; hit_pixel = 1'b1;
    @(negedge clk_25MHz); frame_tick = 1'b0; hit_pixel = 1'b0;
    total++; if (game_state !== 2'd1) begin bad++; $display("FAIL same_cycle_hit got %0d exp 1", game_state); end
    total++; if (crash_count !== 8'd2) begin bad++; $display("FAIL crash_count2 got %0d exp 2", crash_count); end
  endtask

  task automatic test_cloud_wrap();
    do_reset(4'b0000);
    tick(1278);
    total++; if (cloud_offset !== 10'd639) begin bad++; $display("FAIL cloud_639 got %0d exp 639", cloud_offset); end
    tick(2);
    total++; if (cloud_offset !== 10'd0) begin bad++; $display("FAIL cloud_wrap got %0d exp 0", cloud_offset); end
  endtask

  task automatic test_back_to_back();
    do_reset(4'b0000);
    @(negedge clk_25MHz); frame_tick = 1'b1;
    repeat (4) @(negedge clk_25MHz);
    frame_tick = 1'b0;
    total++; if (cloud_offset !== 10'd2) begin bad++; $display("FAIL b2b_cloud got %0d exp 2", cloud_offset); end
  endtask

  task automatic test_reset_in_crash();
    do_reset(4'b0110);
    tick(80);
    total++; if (center_x !== 10'd340) begin bad++; $display("FAIL diag_x got %0d exp 340", center_x); end
    total++; if (center_y !== 10'd220) begin bad++; $display("FAIL diag_y got %0d exp 220", center_y); end
    sw = 4'b0000;
    pulse_hit();
    tick(9);
    total++; if (crash_flash !== 1'b1) begin bad++; $display("FAIL pre_rst_flash got %0b exp 1", crash_flash); end
    @(negedge clk_25MHz); rst_n = 1'b0; frame_tick = 1'b1;
    @(negedge clk_25MHz); rst_n = 1'b1; frame_tick = 1'b0;
    total++; if (center_x !== 10'd320) begin bad++; $display("FAIL rst_crash_x got %0d exp 320", center_x); end
    total++; if (center_y !== 10'd240) begin bad++; $display("FAIL rst_crash_y got %0d exp 240", center_y); end
    total++; if (cloud_offset !== 10'd0) begin bad++; $display("FAIL rst_crash_cloud got %0d exp 0", cloud_offset); end
    total++; if (game_state !== 2'd0) begin bad++; $display("FAIL rst_crash_state got %0d exp 0", game_state); end
    total++; if (crash_flash !== 1'b0) begin bad++; $display("FAIL rst_crash_flash got %0b exp 0", crash_flash); end
    total++; if (crash_count !== 8'd0) begin bad++; $display("FAIL rst_crash_count got %0d exp 0", crash_count); end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_clamp();
    test_crash_cycle();
    test_cloud_wrap();
    test_back_to_back();
    test_reset_in_crash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
